flit_reassembler: RTL and testbench

//  Parametrised multi-flit depacketizer with valid/ready flow control on both sides.
//  - Accepts flits {hdr, data, tag} from the NoC ejection port.
//  - Tracks packet boundaries and checks the declared length against the received length.
//  - Buffers payload words in an output FIFO and flags end-of-packet and errors per word.
//  - Sits between the router ejection port and the core-side consumer.

---
 rtl/flit_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/flit_reassembler.sv | 170 +++++++++++++++++
 tb/tb_flit_reassembler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_pkg.sv
// Shared definitions for the flit reassembler: default field widths,
// FSM states, FIFO entry layout and a saturating counter helper.
package flit_pkg;

    localparam int DEF_HDR_W      = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_TAG_W      = 16;
    localparam int DEF_MAX_LEN    = 64;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_FLIT_W     = DEF_HDR_W + DEF_DATA_W + DEF_TAG_W;
    localparam int DEF_LEN_W      = $clog2(DEF_MAX_LEN + 1);

    // Packet-tracking states: waiting for a header flit, inside a packet,
    // or throwing away the tail of an over-long packet.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BODY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Output FIFO entry layout for the default widths. The top level packs
    // the same field order {data, last, err, len} at its own parameter widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
        logic                  err;
        logic [DEF_LEN_W-1:0]  len;
    } fifo_entry_t;

    // Increment a 16-bit status counter, holding at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? 16'hFFFF : value + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset. Storage is held in registers and
// the head entry is presented directly from the storage array.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; reset flushes every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/flit_reassembler.sv
// Multi-flit depacketizer: tracks packet boundaries from the NoC ejection
// port, checks the declared length, and queues payload words with
// end-of-packet / error / length side information for the core.
module flit_reassembler
    import flit_pkg::*;
#(
    parameter int                 HDR_W      = DEF_HDR_W,
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter int                 TAG_W      = DEF_TAG_W,
    parameter logic [TAG_W-1:0]   END_TAG    = {TAG_W{1'b1}},
    parameter int                 MAX_LEN    = DEF_MAX_LEN,
    parameter int                 FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [HDR_W+DATA_W+TAG_W-1:0]   flit_in,
    input  logic                            flit_valid,
    output logic                            flit_ready,
    output logic [DATA_W-1:0]               data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic                            packet_end,
    output logic [$clog2(MAX_LEN+1)-1:0]    pkt_len,
    output logic                            pkt_err,
    output logic [15:0]                     pkt_count,
    output logic [15:0]                     err_count
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int ENT_W = DATA_W + 2 + LEN_W;

    state_t             state_r;
    logic [LEN_W-1:0]   cnt_r;
    logic [HDR_W-1:0]   exp_r;
    logic [15:0]        pkt_count_r;
    logic [15:0]        err_count_r;

    logic [HDR_W-1:0]   hdr_s;
    logic [DATA_W-1:0]  data_s;
    logic [TAG_W-1:0]   tag_s;
    logic               is_end_s;
    logic [LEN_W-1:0]   cnt_next_s;
    logic               accept_s;
    logic               push_s;
    logic               ent_last_s;
    logic               ent_err_s;
    logic [LEN_W-1:0]   ent_len_s;
    logic [ENT_W-1:0]   push_data_s;
    logic [ENT_W-1:0]   head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    assign hdr_s      = flit_in[HDR_W+DATA_W+TAG_W-1:DATA_W+TAG_W];
    assign data_s     = flit_in[DATA_W+TAG_W-1:TAG_W];
    assign tag_s      = flit_in[TAG_W-1:0];
    assign is_end_s   = (tag_s == END_TAG);
    assign cnt_next_s = cnt_r + LEN_W'(1);

    // Tail flits of an over-long packet are swallowed even when the FIFO is full.
    assign flit_ready = ~reset & ((state_r == DISCARD) | ~fifo_full_s);
    assign accept_s   = flit_valid & flit_ready;

    // Decide whether the accepted flit produces a FIFO entry and what it carries.
    always_comb begin
        push_s     = 1'b0;
        ent_last_s = 1'b0;
        ent_err_s  = 1'b0;
        ent_len_s  = '0;
        case (state_r)
            IDLE: begin
                push_s = accept_s;
                if (is_end_s) begin
                    ent_last_s = 1'b1;
                    ent_len_s  = LEN_W'(1);
                    ent_err_s  = (hdr_s != HDR_W'(1));
                end else begin
                    ent_last_s = 1'b0;
                end
            end
            BODY: begin
                push_s = accept_s;
                if (is_end_s) begin
                    ent_last_s = 1'b1;
                    ent_len_s  = cnt_next_s;
                    ent_err_s  = (HDR_W'(cnt_next_s) != exp_r);
                end else if (cnt_next_s == LEN_W'(MAX_LEN)) begin
                    ent_last_s = 1'b1;
                    ent_len_s  = cnt_next_s;
                    ent_err_s  = 1'b1;
                end else begin
                    ent_last_s = 1'b0;
                end
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    assign push_data_s = {data_s, ent_last_s, ent_err_s, ent_len_s};

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (data_ready),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Packet FSM, length tracking and saturating status counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            exp_r       <= '0;
            pkt_count_r <= 16'd0;
            err_count_r <= 16'd0;
        end else begin
            if (accept_s) begin
                case (state_r)
                    IDLE: begin
                        exp_r <= hdr_s;
                        cnt_r <= LEN_W'(1);
                        if (!is_end_s) begin
                            state_r <= BODY;
                        end
                    end
                    BODY: begin
                        if (is_end_s) begin
                            state_r <= IDLE;
                        end else if (cnt_next_s == LEN_W'(MAX_LEN)) begin
                            state_r <= DISCARD;
                        end else begin
                            cnt_r <= cnt_next_s;
                        end
                    end
                    DISCARD: begin
                        if (is_end_s) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
            if (push_s && ent_last_s) begin
                pkt_count_r <= sat_inc16(pkt_count_r);
                if (ent_err_s) begin
                    err_count_r <= sat_inc16(err_count_r);
                end
            end
        end
    end

    assign data_valid = ~fifo_empty_s;
    assign data_out   = data_valid ? head_s[ENT_W-1 -: DATA_W] : '0;
    assign packet_end = data_valid & head_s[LEN_W+1];
    assign pkt_err    = packet_end & head_s[LEN_W];
    assign pkt_len    = packet_end ? head_s[LEN_W-1:0] : '0;
    assign pkt_count  = pkt_count_r;
    assign err_count  = err_count_r;

endmodule

// File: tb/tb_flit_reassembler.sv
// Directed bench for flit_reassembler with a packet-level reference model
// checked against every output on every cycle.
module tb_flit_reassembler;

    localparam int MAXL  = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [47:0]   flit_in;
    logic          flit_valid;
    logic          flit_ready;
    logic [15:0]   data_out;
    logic          data_valid;
    logic          data_ready;
    logic          packet_end;
    logic [LW-1:0] pkt_len;
    logic          pkt_err;
    logic [15:0]   pkt_count;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    flit_reassembler #(
        .MAX_LEN    (MAXL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flit_in    (flit_in),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .packet_end (packet_end),
        .pkt_len    (pkt_len),
        .pkt_err    (pkt_err),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    typedef struct {
        int d;
        bit e;
        bit er;
        int len;
    } ent_t;

    ent_t mq[$];
    bit   m_in_pkt = 1'b0;
    bit   m_disc   = 1'b0;
    int   m_decl   = 0;
    int   m_n      = 0;
    int   m_pc     = 0;
    int   m_ec     = 0;

    function automatic bit m_ready();
        return !reset && (m_disc || mq.size() < DEPTH);
    endfunction

    function automatic void m_push(input int d, input bit e, input bit er, input int len);
        ent_t x;
        x.d = d; x.e = e; x.er = er; x.len = len;
        mq.push_back(x);
        if (e) begin
            if (m_pc < 65535) m_pc++;
            if (er && m_ec < 65535) m_ec++;
        end
    endfunction

    function automatic void m_flit(input logic [47:0] f);
        int  h;
        int  d;
        bit  last;
        h    = int'(f[47:32]);
        d    = int'(f[31:16]);
        last = (f[15:0] == 16'hFFFF);
        if (m_disc) begin
            if (last) m_disc = 1'b0;
        end else if (!m_in_pkt) begin
            m_decl = h;
            m_n    = 1;
            if (last) m_push(d, 1'b1, h != 1, 1);
            else begin
                m_push(d, 1'b0, 1'b0, 0);
                m_in_pkt = 1'b1;
            end
        end else begin
            m_n++;
            if (last) begin
                m_push(d, 1'b1, m_n != m_decl, m_n);
                m_in_pkt = 1'b0;
            end else if (m_n == MAXL) begin
                m_push(d, 1'b1, 1'b1, m_n);
                m_in_pkt = 1'b0;
                m_disc   = 1'b1;
            end else begin
                m_push(d, 1'b0, 1'b0, 0);
            end
        end
    endfunction

    // Model advance on each rising edge, using inputs held stable since the previous edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                m_in_pkt = 1'b0;
                m_disc   = 1'b0;
                m_pc     = 0;
                m_ec     = 0;
            end else begin
                automatic bit acc = flit_valid && m_ready();
                automatic bit pop = (mq.size() > 0) && data_ready;
                if (pop) void'(mq.pop_front());
                if (acc) m_flit(flit_in);
            end
        end
    end

    // Compare every output against the model on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("flit_ready", flit_ready, m_ready());
            chk("data_valid", data_valid, mq.size() > 0);
            chk("pkt_count", pkt_count, m_pc);
            chk("err_count", err_count, m_ec);
            if (mq.size() > 0) begin
                chk("data_out", data_out, mq[0].d);
                chk("packet_end", packet_end, mq[0].e);
                chk("pkt_err", pkt_err, mq[0].e ? mq[0].er : 1'b0);
                chk("pkt_len", pkt_len, mq[0].e ? mq[0].len : 0);
            end else begin
                chk("data_out_idle", data_out, 0);
                chk("packet_end_idle", packet_end, 0);
                chk("pkt_err_idle", pkt_err, 0);
                chk("pkt_len_idle", pkt_len, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] h, input logic [15:0] d, input logic [15:0] t);
        bit r;
        bit done;
        done       = 1'b0;
        flit_in    = {h, d, t};
        flit_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            r = flit_ready;
            @(posedge clk);
            #1;
            if (r) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: flit %h not accepted within 200 cycles", {h, d, t});
        end
        flit_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        flit_in    = 48'd0;
        flit_valid = 1'b0;
        data_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_flit_ready", flit_ready, 0);
        chk("rst_pkt_count", pkt_count, 0);
        sync();
        reset = 1'b0;

        // 1: single-flit packet
        send(16'd1, 16'hABCD, 16'hFFFF);
        @(negedge clk);
        chk("t1_data", data_out, 16'hABCD);
        chk("t1_end", packet_end, 1);
        chk("t1_len", pkt_len, 1);
        chk("t1_err", pkt_err, 0);
        chk("t1_pkt_count", pkt_count, 1);
        sync();

        // 2: four-flit packet
        send(16'd4, 16'd1, 16'd0);
        send(16'd0, 16'd2, 16'd0);
        send(16'd0, 16'd3, 16'd0);
        send(16'd0, 16'd4, 16'hFFFF);
        @(negedge clk);
        chk("t2_data", data_out, 16'd4);
        chk("t2_end", packet_end, 1);
        chk("t2_len", pkt_len, 4);
        chk("t2_err", pkt_err, 0);
        chk("t2_pkt_count", pkt_count, 2);
        sync();

        // 3: declared 5, ends on flit 3
        send(16'd5, 16'h31, 16'd0);
        send(16'd0, 16'h32, 16'd0);
        send(16'd0, 16'h33, 16'hFFFF);
        @(negedge clk);
        chk("t3_end", packet_end, 1);
        chk("t3_err", pkt_err, 1);
        chk("t3_len", pkt_len, 3);
        chk("t3_err_count", err_count, 1);
        sync();

        // 4: overrun at MAX_LEN=8, tail dropped, then a normal packet
        send(16'd13, 16'h40, 16'd0);
        for (int i = 1; i < 8; i++) send(16'd0, 16'h40 + 16'(i), 16'd0);
        @(negedge clk);
        chk("t4_data", data_out, 16'h47);
        chk("t4_end", packet_end, 1);
        chk("t4_err", pkt_err, 1);
        chk("t4_len", pkt_len, 8);
        chk("t4_err_count", err_count, 2);
        sync();
        for (int i = 8; i < 12; i++) begin
            send(16'd0, 16'h40 + 16'(i), 16'd0);
            @(negedge clk);
            chk("t4_drop_ready", flit_ready, 1);
            sync();
        end
        send(16'd0, 16'h4C, 16'hFFFF);
        @(negedge clk);
        chk("t4_drop_empty", data_valid, 0);
        chk("t4_drop_pkt_count", pkt_count, 4);
        sync();
        send(16'd1, 16'h55, 16'hFFFF);
        @(negedge clk);
        chk("t4_next_data", data_out, 16'h55);
        chk("t4_next_len", pkt_len, 1);
        chk("t4_next_err", pkt_err, 0);
        chk("t4_next_pkt_count", pkt_count, 5);
        sync();

        // 5: backpressure with a 6-flit packet into a 4-deep FIFO
        data_ready = 1'b0;
        fork
            begin
                send(16'd6, 16'h61, 16'd0);
                for (int i = 2; i < 6; i++) send(16'd0, 16'h60 + 16'(i), 16'd0);
                send(16'd0, 16'h66, 16'hFFFF);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                chk("t5_full_ready", flit_ready, 0);
                chk("t5_full_head", data_out, 16'h61);
                sync();
                data_ready = 1'b1;
            end
        join
        repeat (6) sync();
        @(negedge clk);
        chk("t5_drained", data_valid, 0);
        chk("t5_pkt_count", pkt_count, 6);
        sync();

        // 6: reset in the middle of a packet
        send(16'd4, 16'h71, 16'd0);
        send(16'd0, 16'h72, 16'd0);
        reset = 1'b1;
        sync();
        @(negedge clk);
        chk("t6_valid", data_valid, 0);
        chk("t6_ready", flit_ready, 0);
        chk("t6_pkt_count", pkt_count, 0);
        chk("t6_err_count", err_count, 0);
        sync();
        reset = 1'b0;
        send(16'd1, 16'h81, 16'hFFFF);
        @(negedge clk);
        chk("t6_data", data_out, 16'h81);
        chk("t6_len", pkt_len, 1);
        chk("t6_pkt_count", pkt_count, 1);
        sync();

        repeat (3) sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
